s2p_deframer: RTL

Serial-to-parallel deframer sitting directly downstream of the 16-bit parallel-to-serial converter. Consumes the serial bit stream and its one-cycle frame-sync pulse, reassembles MSB-first words, and buffers them in a small FIFO. The FIFO is presented to the parallel consumer through a valid/ready handshake. Detects truncated frames and buffer overflow.

---
 rtl/s2p_pkg.sv | 20 ++
 rtl/s2p_fifo.sv | 75 +++++++
 rtl/s2p_deframer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/s2p_pkg.sv
`default_nettype none
// ============================================================================
// Package  : s2p_pkg
// Brief    : Shared types and defaults for the serial-to-parallel deframer.
// Revision : 1.0 - initial release
// ============================================================================
package s2p_pkg;

    // Deframer capture states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } s2p_state_e;

    localparam int S2P_WIDTH_DEF = 16;
    localparam int S2P_DEPTH_DEF = 4;
    localparam int ERR_CNT_W     = 8;

endpackage : s2p_pkg
`default_nettype wire

// File: rtl/s2p_fifo.sv
`default_nettype none
// ============================================================================
// Module   : s2p_fifo
// Brief    : First-word-fall-through FIFO, WIDTH x DEPTH (DEPTH power of 2).
//            A push into a full FIFO is accepted only when a pop happens in
//            the same cycle; otherwise the push is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module s2p_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem_q [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_CNT_W-1:0] r_cnt_q,    w_cnt_d;
    logic               w_wr_en;
    logic               w_rd_en;

    assign o_full  = (r_cnt_q == c_CNT_W'(DEPTH));
    assign o_empty = (r_cnt_q == '0);
    assign w_rd_en = i_pop && !o_empty;
    assign w_wr_en = i_push && (!o_full || w_rd_en);

    // Head word is forced to zero while empty so dout is clean after reset
    assign o_rdata = o_empty ? '0 : r_mem_q[r_rd_ptr_q];

    // Next-state pointers and occupancy
    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_cnt_d    = r_cnt_q + c_CNT_W'(w_wr_en) - c_CNT_W'(w_rd_en);
        if (w_wr_en) begin
            w_wr_ptr_d = r_wr_ptr_q + c_PTR_W'(1);
        end
        if (w_rd_en) begin
            w_rd_ptr_d = r_rd_ptr_q + c_PTR_W'(1);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_cnt_q    <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_cnt_q    <= w_cnt_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_q[r_wr_ptr_q] <= i_wdata;
        end
    end

endmodule : s2p_fifo
`default_nettype wire

// File: rtl/s2p_deframer.sv
`default_nettype none
// ============================================================================
// Module   : s2p_deframer
// Brief    : Serial-to-parallel deframer. A one-cycle fs_in pulse starts a
//            frame of WIDTH MSB-first bits; completed words go into an FWFT
//            FIFO read through dvalid/dready. Flags early frame sync
//            (frm_err pulse) and words dropped on a full FIFO (sticky ovf).
// Options  : S2P_ERR_CNT_EN - adds saturating error counter output err_cnt
// Revision : 1.0 - initial release
// ============================================================================
module s2p_deframer
    import s2p_pkg::*;
#(
    parameter int WIDTH = S2P_WIDTH_DEF,
    parameter int DEPTH = S2P_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sdin,
    input  logic                       fs_in,
    output logic [WIDTH-1:0]           dout,
    output logic                       dvalid,
    input  logic                       dready,
    output logic [$clog2(WIDTH+1)-1:0] count,
    output logic                       busy,
    output logic                       frm_err,
    output logic                       ovf
`ifdef S2P_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0]       err_cnt
`endif
);

    localparam int                 c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    s2p_state_e         r_state_q,   w_state_d;
    logic [c_CNT_W-1:0] r_count_q,   w_count_d;
    logic [WIDTH-1:0]   r_shreg_q,   w_shreg_d;
    logic               r_frm_err_q, w_frm_err_d;
    logic               r_ovf_q,     w_ovf_d;
    logic               w_push;
    logic               w_full;
    logic               w_empty;
    logic               w_drop;

    // Capture FSM: frame start, bit shifting, early-sync abort, word push
    always_comb begin
        w_state_d   = r_state_q;
        w_count_d   = r_count_q;
        w_shreg_d   = r_shreg_q;
        w_frm_err_d = 1'b0;
        w_push      = 1'b0;
        case (r_state_q)
            IDLE: begin
                if (fs_in) begin
                    w_state_d = SHIFT;
                    w_count_d = '0;
                end
            end
            SHIFT: begin
                if (fs_in) begin
                    // Early sync wins even on the last bit: drop partial word
                    w_frm_err_d = 1'b1;
                    w_count_d   = '0;
                end else begin
                    w_shreg_d = {r_shreg_q[WIDTH-2:0], sdin};
                    if (r_count_q == c_LAST) begin
                        w_push    = 1'b1;
                        w_state_d = IDLE;
                        w_count_d = '0;
                    end else begin
                        w_count_d = r_count_q + 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = IDLE;
                w_count_d = '0;
            end
        endcase
    end

    // A push into a full FIFO survives only if the consumer pops that cycle
    assign w_drop  = w_push && w_full && !(dvalid && dready);
    assign w_ovf_d = r_ovf_q || w_drop;

    // Deframer state and flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q   <= IDLE;
            r_count_q   <= '0;
            r_shreg_q   <= '0;
            r_frm_err_q <= 1'b0;
            r_ovf_q     <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_count_q   <= w_count_d;
            r_shreg_q   <= w_shreg_d;
            r_frm_err_q <= w_frm_err_d;
            r_ovf_q     <= w_ovf_d;
        end
    end

    s2p_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_shreg_d),
        .i_pop   (dready),
        .o_rdata (dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign dvalid  = !w_empty;
    assign count   = r_count_q;
    assign busy    = (r_state_q == SHIFT);
    assign frm_err = r_frm_err_q;
    assign ovf     = r_ovf_q;

`ifdef S2P_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_err_cnt_q, w_err_cnt_d;
    logic [ERR_CNT_W:0]   w_err_sum;

    // Saturating sum of abort and drop events; both in one cycle add two
    always_comb begin
        w_err_sum   = {1'b0, r_err_cnt_q}
                    + (ERR_CNT_W + 1)'(w_frm_err_d)
                    + (ERR_CNT_W + 1)'(w_drop);
        w_err_cnt_d = w_err_sum[ERR_CNT_W] ? '1 : w_err_sum[ERR_CNT_W-1:0];
    end

    // Error counter register, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_cnt_q <= '0;
        end else begin
            r_err_cnt_q <= w_err_cnt_d;
        end
    end

    assign err_cnt = r_err_cnt_q;
`endif

endmodule : s2p_deframer
`default_nettype wire
